// File: rtl/regfile_writeback.sv
// Write-back front end for the 64x16 register file: in-order result FIFO fed by
// the ALU and load unit, retiring up to two entries per cycle onto two write ports.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     res0_valid,
  output logic                     res0_ready,
  input  logic [AW-1:0]            res0_dest,
  input  logic [DW-1:0]            res0_data,
  input  logic                     res1_valid,
  output logic                     res1_ready,
  input  logic [AW-1:0]            res1_dest,
  input  logic [DW-1:0]            res1_data,
  input  logic                     wb_stall,
  output logic [AW-1:0]            reg_wr1,
  output logic [DW-1:0]            reg_wr1_data,
  output logic                     reg_wr1_enable,
  output logic [AW-1:0]            reg_wr2,
  output logic [DW-1:0]            reg_wr2_data,
  output logic                     reg_wr2_enable,
  input  logic [AW-1:0]            pend_addr,
  output logic                     pend_hit,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] dest_q [DEPTH];
  logic [AW-1:0] dest_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic          acc0, acc1;
  logic [PW-1:0] slot0, slot1;
  logic [PW-1:0] head_p1;

  // Ready is based only on registered occupancy; no credit for same-cycle retirement
  always_comb begin
    res0_ready = reset & (count_q <= CW'(DEPTH - 1));
    res1_ready = reset & ((count_q <= CW'(DEPTH - 2)) |
                          ((count_q == CW'(DEPTH - 1)) & ~res0_valid));
    acc0       = res0_valid & res0_ready;
    acc1       = res1_valid & res1_ready;
  end

  // Retirement ports read the two oldest slots directly from registered state
  always_comb begin
    head_p1        = head_q + PW'(1);
    reg_wr1        = dest_q[head_q];
    reg_wr1_data   = data_q[head_q];
    reg_wr1_enable = (count_q >= CW'(1)) & ~wb_stall;
    reg_wr2        = dest_q[head_p1];
    reg_wr2_data   = data_q[head_p1];
    reg_wr2_enable = (count_q >= CW'(2)) & ~wb_stall;
    wb_count       = count_q;
  end

  // Hazard query over occupied slots only, walking from the head
  always_comb begin
    pend_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (dest_q[head_q + PW'(i)] == pend_addr)) begin
        pend_hit = 1'b1;
      end
    end
  end

  // res0 is older, so it takes the tail slot and res1 the one after it
  always_comb begin
    slot0   = tail_q;
    slot1   = tail_q + PW'(acc0);
    dest_d  = dest_q;
    data_d  = data_q;
    if (acc0) begin
      dest_d[slot0] = res0_dest;
      data_d[slot0] = res0_data;
    end
    if (acc1) begin
      dest_d[slot1] = res1_dest;
      data_d[slot1] = res1_data;
    end
    tail_d  = tail_q + PW'(acc0) + PW'(acc1);
    head_d  = head_q + PW'(reg_wr1_enable) + PW'(reg_wr2_enable);
    count_d = count_q + CW'(acc0) + CW'(acc1)
              - CW'(reg_wr1_enable) - CW'(reg_wr2_enable);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

endmodule
